// File: rtl/instr_sequencer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// instr_sequencer_if : core-side bundle between decoder/IRQ controller and
//                      the instruction timing sequencer.
// Revision: 1.0
// ---------------------------------------------------------------------------
interface instr_sequencer_if #(
  parameter int ID_WIDTH = 8
);
  logic [ID_WIDTH-1:0] instruction_id;
  logic                branch_taken;
  logic                irq_pending;
  logic                sreg_i;
  logic [1:0]          clock_counter;
  logic [1:0]          interrupt_stage;
  logic                instr_first;
  logic                ir_load;
  logic                pc_hold;
  logic                irq_ack;

  modport master (
    output instruction_id, branch_taken, irq_pending, sreg_i,
    input  clock_counter, interrupt_stage, instr_first, ir_load, pc_hold, irq_ack
  );

  modport slave (
    input  instruction_id, branch_taken, irq_pending, sreg_i,
    output clock_counter, interrupt_stage, instr_first, ir_load, pc_hold, irq_ack
  );
endinterface
`default_nettype wire

// File: rtl/instr_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// instr_sequencer : per-instruction cycle counter, fetch request and 3-stage
//                   interrupt entry sequencer for the AVR core.
// Revision: 1.0
// ---------------------------------------------------------------------------
module instr_sequencer #(
  parameter int ID_WIDTH               = 8,
  parameter bit INHIBIT_AFTER_SEI_RETI = 1'b1
) (
  input  wire logic         clk,
  input  wire logic         reset,
  instr_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    S_BOOT = 3'd0,
    S_RUN  = 3'd1,
    S_INT2 = 3'd2,
    S_INT1 = 3'd3,
    S_INT3 = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic       first_q, first_d;
  logic       inhibit_q, inhibit_d;

  logic [1:0] w_load;
  logic [1:0] w_clock_counter;
  logic [1:0] w_stage;
  logic       w_instr_first;
  logic       w_ir_load;
  logic       w_pc_hold;
  logic       w_irq_ack;
  logic       w_take_irq;
  logic       w_sei_reti;
  logic       w_branch;

  assign w_branch   = (bus.instruction_id >= ID_WIDTH'(8'h04)) &&
                      (bus.instruction_id <= ID_WIDTH'(8'h08));
  assign w_sei_reti = (bus.instruction_id == ID_WIDTH'(8'h32)) ||
                      (bus.instruction_id == ID_WIDTH'(8'h2E));
  assign w_take_irq = bus.irq_pending & bus.sreg_i & ~inhibit_q;

  always_comb begin
    w_load = 2'd0;
    if (w_branch) begin
      w_load = {1'b0, bus.branch_taken};
    end else begin
      case (bus.instruction_id)
        ID_WIDTH'(8'h2D), ID_WIDTH'(8'h2E): w_load = 2'd3;
        ID_WIDTH'(8'h2C), ID_WIDTH'(8'h22): w_load = 2'd2;
        ID_WIDTH'(8'h19), ID_WIDTH'(8'h38), ID_WIDTH'(8'h2B),
        ID_WIDTH'(8'h2A), ID_WIDTH'(8'h2F): w_load = 2'd1;
        default:                            w_load = 2'd0;
      endcase
    end
  end

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    first_d         = first_q;
    inhibit_d       = inhibit_q;
    w_clock_counter = 2'd0;
    w_stage         = 2'd0;
    w_instr_first   = 1'b0;
    w_ir_load       = 1'b0;
    w_pc_hold       = 1'b1;
    w_irq_ack       = 1'b0;
    case (state_q)
      S_BOOT: begin
        w_ir_load = 1'b1;
        w_pc_hold = 1'b0;
        state_d   = S_RUN;
        first_d   = 1'b1;
      end
      S_RUN: begin
        w_clock_counter = first_q ? w_load : cnt_q;
        w_instr_first   = first_q;
        if (w_clock_counter != 2'd0) begin
          cnt_d   = w_clock_counter - 2'd1;
          first_d = 1'b0;
        end else begin
          // Boundary: the previous instruction's inhibit expires here.
          inhibit_d = INHIBIT_AFTER_SEI_RETI & w_sei_reti;
          cnt_d     = 2'd0;
          if (w_take_irq) begin
            state_d = S_INT2;
            first_d = 1'b0;
          end else begin
            w_ir_load = 1'b1;
            w_pc_hold = 1'b0;
            first_d   = 1'b1;
          end
        end
      end
      S_INT2: begin
        w_stage = 2'd2;
        state_d = S_INT1;
      end
      S_INT1: begin
        w_stage = 2'd1;
        state_d = S_INT3;
      end
      S_INT3: begin
        w_stage   = 2'd3;
        w_irq_ack = 1'b1;
        w_ir_load = 1'b1;
        w_pc_hold = 1'b0;
        state_d   = S_RUN;
        first_d   = 1'b1;
      end
      default: begin
        state_d = S_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_BOOT;
      cnt_q     <= 2'd0;
      first_q   <= 1'b0;
      inhibit_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      first_q   <= first_d;
      inhibit_q <= inhibit_d;
    end
  end

  // BOOT drives a fetch, so reset must mask the fetch outputs directly.
  assign bus.clock_counter   = w_clock_counter;
  assign bus.interrupt_stage = w_stage;
  assign bus.instr_first     = w_instr_first;
  assign bus.irq_ack         = w_irq_ack;
  assign bus.ir_load         = w_ir_load & ~reset;
  assign bus.pc_hold         = w_pc_hold | reset;

endmodule
`default_nettype wire

// File: tb/tb_instr_sequencer.sv
`default_nettype none
// Randomised scoreboard bench for instr_sequencer: a cycle-level reference
// model derived from instruction lengths queues expected outputs per cycle.
module tb_instr_sequencer;

  localparam int ID_WIDTH = 8;
  localparam bit INH      = 1'b1;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  instr_sequencer_if #(.ID_WIDTH(ID_WIDTH)) bus ();

  instr_sequencer #(
    .ID_WIDTH               (ID_WIDTH),
    .INHIBIT_AFTER_SEI_RETI (INH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [1:0] cc;
    logic [1:0] stage;
    logic       first;
    logic       ir_load;
    logic       pc_hold;
    logic       ack;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e, mon_a;
  int   checks   = 0;
  int   failures = 0;
  bit   m_inh    = 1'b0;

  // Monitor: one expected entry per cycle, compared mid low phase.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        mon_a = '{bus.clock_counter, bus.interrupt_stage, bus.instr_first,
                  bus.ir_load, bus.pc_hold, bus.irq_ack};
        checks++;
        if (mon_a !== mon_e) begin
          failures++;
          $display("FAIL cycle t=%0t id=%h got cc=%0d st=%0d first=%b ld=%b hold=%b ack=%b required cc=%0d st=%0d first=%b ld=%b hold=%b ack=%b",
                   $time, bus.instruction_id, mon_a.cc, mon_a.stage, mon_a.first,
                   mon_a.ir_load, mon_a.pc_hold, mon_a.ack, mon_e.cc, mon_e.stage,
                   mon_e.first, mon_e.ir_load, mon_e.pc_hold, mon_e.ack);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s got %0d required %0d", name, act, req);
    end
  endtask

  task automatic check_reset_values();
    chk("rst_clock_counter", int'(bus.clock_counter), 0);
    chk("rst_interrupt_stage", int'(bus.interrupt_stage), 0);
    chk("rst_instr_first", int'(bus.instr_first), 0);
    chk("rst_ir_load", int'(bus.ir_load), 0);
    chk("rst_irq_ack", int'(bus.irq_ack), 0);
    chk("rst_pc_hold", int'(bus.pc_hold), 1);
  endtask

  // Extra execution cycles of an instruction beyond its first.
  function automatic int extra_cycles(input logic [7:0] id, input bit br);
    if (id >= 8'h04 && id <= 8'h08) return br ? 1 : 0;
    case (id)
      8'h2D, 8'h2E:                      return 3;
      8'h2C, 8'h22:                      return 2;
      8'h19, 8'h38, 8'h2B, 8'h2A, 8'h2F: return 1;
      default:                           return 0;
    endcase
  endfunction

  task automatic drive(input logic [7:0] id, input bit br, input bit irq,
                       input bit sreg, input exp_t e);
    @(negedge clk);
    bus.instruction_id = id;
    bus.branch_taken   = br;
    bus.irq_pending    = irq;
    bus.sreg_i         = sreg;
    exp_q.push_back(e);
  endtask

  task automatic release_reset();
    exp_t e;
    @(negedge clk);
    reset = 1'b0;
    m_inh = 1'b0;
    e = '{2'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    exp_q.push_back(e);
  endtask

  // Interrupt entry: stages 2,1,3; optional reset pulled during stage 1.
  task automatic irq_entry(input bit abort);
    int   stg[3] = '{2, 1, 3};
    exp_t e;
    for (int s = 0; s < 3; s++) begin
      e.cc      = 2'd0;
      e.stage   = stg[s][1:0];
      e.first   = 1'b0;
      e.ir_load = (stg[s] == 3);
      e.pc_hold = (stg[s] != 3);
      e.ack     = (stg[s] == 3);
      drive(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), e);
      if (abort && stg[s] == 1) begin
        #3 reset = 1'b1;
        #1 check_reset_values();
        return;
      end
    end
  endtask

  task automatic run_instr(input logic [7:0] id, input bit br, input bit irq_b,
                           input bit sreg_b, input bit abort = 1'b0);
    int   l;
    bit   take;
    exp_t e;
    l    = extra_cycles(id, br);
    take = irq_b & sreg_b & ~m_inh;
    for (int k = l; k >= 0; k--) begin
      e.cc      = k[1:0];
      e.stage   = 2'd0;
      e.first   = (k == l);
      e.ir_load = (k == 0) && !take;
      e.pc_hold = !((k == 0) && !take);
      e.ack     = 1'b0;
      drive(id, (k == l) ? br : 1'($urandom),
            (k == 0) ? irq_b : 1'($urandom),
            (k == 0) ? sreg_b : 1'($urandom), e);
    end
    m_inh = INH && (id == 8'h32 || id == 8'h2E);
    if (take) irq_entry(abort);
  endtask

  logic [7:0] pool[16] = '{8'h00, 8'h19, 8'h38, 8'h2B, 8'h2A, 8'h2F, 8'h2C, 8'h22,
                           8'h2D, 8'h2E, 8'h32, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};

  initial begin
    bus.instruction_id = 8'h00;
    bus.branch_taken   = 1'b0;
    bus.irq_pending    = 1'b0;
    bus.sreg_i         = 1'b0;
    #1 reset = 1'b1;
    #1 check_reset_values();
    repeat (2) @(negedge clk);
    release_reset();

    repeat (3) run_instr(8'h00, 1'b0, 1'b0, 1'b0);
    run_instr(8'h2C, 1'b0, 1'b0, 1'b1);
    run_instr(8'h2D, 1'b0, 1'b0, 1'b1);
    run_instr(8'h05, 1'b1, 1'b0, 1'b1);
    run_instr(8'h05, 1'b0, 1'b0, 1'b1);
    run_instr(8'h22, 1'b0, 1'b1, 1'b1);
    run_instr(8'h00, 1'b0, 1'b0, 1'b1);
    run_instr(8'h32, 1'b0, 1'b0, 1'b0);
    run_instr(8'h00, 1'b0, 1'b1, 1'b1);
    run_instr(8'h00, 1'b0, 1'b1, 1'b1);
    run_instr(8'h2E, 1'b0, 1'b0, 1'b1);
    run_instr(8'h00, 1'b0, 1'b1, 1'b1);
    run_instr(8'h00, 1'b0, 1'b1, 1'b1);

    for (int n = 0; n < 200; n++) begin
      logic [7:0] id;
      id = ($urandom_range(0, 7) == 0) ? 8'($urandom) : pool[$urandom_range(0, 15)];
      run_instr(id, 1'($urandom), $urandom_range(0, 3) == 0, 1'($urandom));
    end

    // Take an interrupt and pull reset in the middle of its entry.
    run_instr(8'h00, 1'b0, 1'b0, 1'b0);
    run_instr(8'h2B, 1'b0, 1'b1, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    release_reset();
    repeat (3) run_instr(8'h00, 1'b0, 1'b0, 1'b0);
    run_instr(8'h2C, 1'b0, 1'b0, 1'b0);

    @(negedge clk);
    #3;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
